store_merge_unit: RTL and testbench
===================================

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset, with the reset asynchronous and active-high; both are listed as the first two ports below.
REQ-002 clk  in  1  Rising-edge clock for all state.
REQ-003 reset  in  1  Asynchronous active-high reset.
REQ-004 start  in  1  Store request; sampled only in IDLE.
REQ-005 addr  in  32  Byte address of the store.
REQ-006 wdata  in  32  Store data, right-justified (byte in [7:0], half in [15:0]).
REQ-007 size  in  2  Store width: 00 word, 01 halfword, 10 byte, 11 treated as word.
REQ-008 busy  out  1  High in every state except IDLE.
REQ-009 done  out  1  One-cycle completion pulse.
REQ-010 err  out  1  One-cycle misalignment flag, coincident with done.
REQ-011 mem_addr  out  32  Word address to memory, {addr_q[31:2],2'b00}.
REQ-012 mem_rd_en  out  1  Read strobe; memory returns data one cycle later.
REQ-013 mem_rdata  in  32  Read data, valid the cycle after mem_rd_en.
REQ-014 mem_we  out  1  Full-word write strobe (memory has no byte enables).
REQ-015 mem_wdata  out  32  Merged write word.

Function
REQ-016 The FSM SHALL have states IDLE, RD, WAIT, WR, DONE, with outputs decoded from state (Moore).
REQ-017 In IDLE with start=1, addr, wdata and size SHALL be latched into addr_q, wdata_q and size_q.
REQ-018 Transition IDLE->WR SHALL occur for a word store; IDLE->RD for an aligned half or byte store; IDLE->DONE with err latched for a misaligned store.
REQ-019 Misaligned SHALL mean: word with addr[1:0]!=00, or half with addr[0]=1; byte is never misaligned.
REQ-020 RD SHALL assert mem_rd_en for one cycle and then go to WAIT.
REQ-021 WAIT SHALL capture mem_rdata into old_q and then go to WR.
REQ-022 WR SHALL assert mem_we for one cycle with mem_wdata = merged word, and then go to DONE.
REQ-023 The merge SHALL work as follows.
- Word: mem_wdata = wdata_q.
- Half: replace old_q[16*addr_q[1]+:16] with wdata_q[15:0].
- Byte: replace old_q[8*addr_q[1:0]+:8] with wdata_q[7:0].
- All other bits SHALL come unchanged from old_q.
REQ-024 DONE SHALL assert done=1 (and err=err_q) for one cycle, then return to IDLE; err_q SHALL be cleared on return to IDLE.
REQ-025 Latency from the start cycle to done SHALL be: word 2 cycles; half/byte 4 cycles; misaligned 1 cycle.
REQ-026 start SHALL be ignored while busy=1; start in the cycle done=1 SHALL also be ignored (DONE is not IDLE).
REQ-027 mem_rd_en and mem_we SHALL never be asserted in the same cycle.
REQ-028 A misaligned request SHALL produce no mem_rd_en and no mem_we.
REQ-029 mem_addr SHALL be driven from addr_q in all states.
REQ-030 Input changes after the start cycle SHALL NOT affect the operation in progress.

Reset
REQ-031 On reset assertion, the state SHALL immediately become IDLE, and busy, done, err, mem_rd_en and mem_we SHALL be 0.
REQ-032 On reset, addr_q, wdata_q, old_q and err_q SHALL become 0, so mem_addr=0 and mem_wdata=0.
REQ-033 Reset asserted during RD/WAIT/WR SHALL abort the operation, with no mem_we pulse after assertion and no done.
REQ-034 The first start SHALL be honoured on the first rising edge after reset deasserts.

Verification
REQ-035 Word store: addr=0x100, wdata=0xDEADBEEF, size=00 -> the next cycle has mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; done 2 cycles after start; mem_rd_en never asserted.
REQ-036 Byte store: addr=0x203, wdata=0x000000AB, size=10, memory word=0x11223344 -> mem_rd_en, then mem_we with mem_wdata=0xAB223344 at mem_addr=0x200; done at cycle 4.
REQ-037 Half store: addr=0x302, wdata=0x0000CAFE, size=01, memory=0x11223344 -> mem_wdata=0xCAFE3344; same half at addr=0x300 -> 0x1122CAFE.
REQ-038 Misaligned: half at addr=0x301 and word at 0x102 -> done=err=1 one cycle after start, no mem_rd_en/mem_we, memory unchanged.
REQ-039 Reset and start-while-busy handling SHALL be checked as follows.
- Assert reset in the WAIT cycle of a byte store -> no mem_we and no done, outputs 0.
- After reset, a new word store completes normally.
- Pulse start while busy=1 -> no second operation.

Source files
------------

// File: rtl/store_merge_unit.sv
// Sub-word store engine: widens byte/halfword stores into full-word writes
// by reading the old word, merging the new bytes in, and writing it back.
module store_merge_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  state_t      state;
  state_t      state_next;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic [31:0] old_q;
  logic        err_q;

  logic        req_half;
  logic        req_byte;
  logic        req_word;
  logic        req_misaligned;

  logic [4:0]  half_lsb;
  logic [4:0]  byte_lsb;
  logic [31:0] merged;

  // Size 11 is deliberately folded into the word case.
  always_comb begin
    req_half       = (size == SIZE_HALF);
    req_byte       = (size == SIZE_BYTE);
    req_word       = !req_half && !req_byte;
    req_misaligned = (req_word && (addr[1:0] != 2'b00)) ||
                     (req_half && addr[0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (req_misaligned) begin
            state_next = DONE;
          end else if (req_word) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = WAIT;
      WAIT:    state_next = WR;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance so later input changes cannot
  // disturb an operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      old_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            size_q  <= size;
            err_q   <= req_misaligned;
          end
        end
        WAIT:    old_q <= mem_rdata;
        DONE:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Lanes not covered by the store keep the value read from memory.
  always_comb begin
    half_lsb = {addr_q[1], 4'b0000};
    byte_lsb = {addr_q[1:0], 3'b000};
    merged   = old_q;
    case (size_q)
      SIZE_HALF: merged[half_lsb +: 16] = wdata_q[15:0];
      SIZE_BYTE: merged[byte_lsb +: 8]  = wdata_q[7:0];
      default:   merged = wdata_q;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    err       = (state == DONE) && err_q;
    mem_rd_en = (state == RD);
    mem_we    = (state == WR);
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = merged;
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: a simple word memory plus a
// byte-mask reference model of what each store should leave in memory.
module tb_store_merge_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;

  logic [31:0] mem [0:1023];

  int nChecks = 0;
  int nFails  = 0;

  store_merge_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addr      (addr),
    .wdata     (wdata),
    .size      (size),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns read data one cycle after the strobe; writes are full-word.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr[11:2]];
    if (mem_we)    mem[mem_addr[11:2]] <= mem_wdata;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] global time limit expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one store, scramble the inputs afterwards, and check the whole
  // transaction against the reference model.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] s, input bit pulseBusy);
    logic [31:0] oldWord, expWord, mask;
    int          shamt, expLat, expRd, expWe, lat, rdCnt, weCnt, both;
    bit          expErr, mis;
    logic        gotErr;
    logic [31:0] weData, weAddr;

    oldWord = mem[a[11:2]];
    mis = ((s == 2'b00 || s == 2'b11) && (a % 4 != 0)) || (s == 2'b01 && (a % 2 != 0));
    if (mis) begin
      expLat = 1; expRd = 0; expWe = 0; expErr = 1; expWord = oldWord;
    end else if (s == 2'b00 || s == 2'b11) begin
      expLat = 2; expRd = 0; expWe = 1; expErr = 0; expWord = d;
    end else begin
      expLat = 4; expRd = 1; expWe = 1; expErr = 0;
      if (s == 2'b01) begin
        shamt = ((a % 4) / 2) * 16;
        mask  = 32'h0000FFFF << shamt;
      end else begin
        shamt = (a % 4) * 8;
        mask  = 32'h000000FF << shamt;
      end
      expWord = (oldWord & ~mask) | ((d << shamt) & mask);
    end

    lat = 0; rdCnt = 0; weCnt = 0; both = 0; gotErr = 1'bx;
    weData = 32'hx; weAddr = 32'hx;

    @(negedge clk);
    start = 1'b1; addr = a; wdata = d; size = s;
    @(posedge clk); #1;
    start = pulseBusy;
    addr  = $urandom; wdata = $urandom; size = 2'($urandom_range(0, 3));

    for (int c = 1; c <= 8; c++) begin
      if (mem_rd_en) rdCnt++;
      if (mem_we) begin weCnt++; weData = mem_wdata; weAddr = mem_addr; end
      if (mem_rd_en && mem_we) both++;
      if (done) begin lat = c; gotErr = err; break; end
      @(posedge clk); #1;
    end

    checkOutput("busyInDone", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    if (mem_rd_en) rdCnt++;
    if (mem_we) weCnt++;
    checkOutput("idleAfterDone", {30'b0, busy, done}, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    if (mem_rd_en) rdCnt++;
    if (mem_we) weCnt++;
    checkOutput("noSecondOp", {31'b0, busy}, 32'd0);

    checkOutput("latency", lat, expLat);
    checkOutput("errFlag", {31'b0, gotErr}, {31'b0, expErr});
    checkOutput("rdCount", rdCnt, expRd);
    checkOutput("weCount", weCnt, expWe);
    checkOutput("rdWeOverlap", both, 0);
    if (expWe == 1) begin
      checkOutput("weData", weData, expWord);
      checkOutput("weAddr", weAddr, a & 32'hFFFFFFFC);
    end
    checkOutput("memWord", mem[a[11:2]], expWord);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; addr = '0; wdata = '0; size = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    #12;
    checkOutput("rstCtrl", {27'b0, busy, done, err, mem_rd_en, mem_we}, 32'd0);
    checkOutput("rstAddr", mem_addr, 32'd0);
    checkOutput("rstWdata", mem_wdata, 32'd0);

    @(posedge clk); #3 reset = 1'b0;
    $display("[TB] word store 0x100");
    applyStimulus(32'h100, 32'hDEADBEEF, 2'b00, 1'b0);
    checkOutput("wordVector", mem[32'h100 >> 2], 32'hDEADBEEF);

    $display("[TB] byte store 0x203");
    mem[32'h200 >> 2] = 32'h11223344;
    applyStimulus(32'h203, 32'h000000AB, 2'b10, 1'b0);
    checkOutput("byteVector", mem[32'h200 >> 2], 32'hAB223344);

    $display("[TB] half stores 0x302 / 0x300");
    mem[32'h300 >> 2] = 32'h11223344;
    applyStimulus(32'h302, 32'h0000CAFE, 2'b01, 1'b0);
    checkOutput("halfHiVector", mem[32'h300 >> 2], 32'hCAFE3344);
    mem[32'h300 >> 2] = 32'h11223344;
    applyStimulus(32'h300, 32'h0000CAFE, 2'b01, 1'b1);
    checkOutput("halfLoVector", mem[32'h300 >> 2], 32'h1122CAFE);

    $display("[TB] misaligned stores");
    applyStimulus(32'h301, 32'h12345678, 2'b01, 1'b0);
    applyStimulus(32'h102, 32'h87654321, 2'b00, 1'b1);
    applyStimulus(32'h107, 32'h0BADF00D, 2'b11, 1'b0);

    $display("[TB] reset during WAIT of a byte store");
    mem[32'h200 >> 2] = 32'h11223344;
    @(negedge clk);
    start = 1'b1; addr = 32'h203; wdata = 32'h000000AB; size = 2'b10;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    checkOutput("inWait", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abortCtrl", {27'b0, busy, done, err, mem_rd_en, mem_we}, 32'd0);
    checkOutput("abortAddr", mem_addr, 32'd0);
    checkOutput("abortWdata", mem_wdata, 32'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (mem_we || done || busy) seen++;
      end
      checkOutput("abortQuiet", seen, 0);
    end
    checkOutput("abortMem", mem[32'h200 >> 2], 32'h11223344);
    @(posedge clk); #3 reset = 1'b0;
    applyStimulus(32'h040, 32'hA5A55A5A, 2'b00, 1'b0);

    $display("[TB] randomized stores");
    for (int n = 0; n < 24; n++) begin
      applyStimulus(32'($urandom_range(0, 4095)), $urandom,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
